// File: rtl/result_uart_tx_if.sv
// rtl/result_uart_tx_if.sv - match-result strobe and coordinates feeding the result UART
interface result_uart_tx_if;
   logic       result_valid;
   logic [9:0] x_in;
   logic [8:0] y_in;

   modport master (output result_valid, output x_in, output y_in);
   modport slave  (input  result_valid, input  x_in, input  y_in);
endinterface

// File: rtl/result_uart_tx.sv
// rtl/result_uart_tx.sv - sends each SAD match (x, y) to the host as "XXXX,YYY\r\n" over 8N1 UART
module result_uart_tx #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int BIT_CYCLES = CLK_FREQ / BAUD
) (
   input  logic             clock,
   input  logic             reset,
   result_uart_tx_if.slave  result,
   output logic             TxD,
   output logic             busy,
   output logic             send_complete,
   output logic             dropped
);

   localparam int             CW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0]  BAUD_LAST = CW'(BIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, CONV, START, SEND} state_t;

   state_t          state;
   logic [25:0]     x_sr;
   logic [21:0]     y_sr;
   logic [3:0]      conv_cnt;
   logic [CW-1:0]   baud_cnt;
   logic [3:0]      bit_idx;
   logic [3:0]      byte_idx;
   logic [7:0]      cur_byte;

   function automatic logic [3:0] adj3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   // One double-dabble step: correct every BCD digit, then shift the whole register left.
   function automatic logic [25:0] dabble_x(input logic [25:0] s);
      logic [25:0] t;
      t = {adj3(s[25:22]), adj3(s[21:18]), adj3(s[17:14]), adj3(s[13:10]), s[9:0]};
      return t << 1;
   endfunction

   function automatic logic [21:0] dabble_y(input logic [21:0] s);
      logic [21:0] t;
      t = {adj3(s[21:18]), adj3(s[17:14]), adj3(s[13:10]), s[9:0]};
      return t << 1;
   endfunction

   always_comb begin
      cur_byte = 8'h0A;
      case (byte_idx)
         4'd0:    cur_byte = {4'h3, x_sr[25:22]};
         4'd1:    cur_byte = {4'h3, x_sr[21:18]};
         4'd2:    cur_byte = {4'h3, x_sr[17:14]};
         4'd3:    cur_byte = {4'h3, x_sr[13:10]};
         4'd4:    cur_byte = 8'h2C;
         4'd5:    cur_byte = {4'h3, y_sr[21:18]};
         4'd6:    cur_byte = {4'h3, y_sr[17:14]};
         4'd7:    cur_byte = {4'h3, y_sr[13:10]};
         4'd8:    cur_byte = 8'h0D;
         default: cur_byte = 8'h0A;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         x_sr          <= '0;
         y_sr          <= '0;
         conv_cnt      <= '0;
         baud_cnt      <= '0;
         bit_idx       <= '0;
         byte_idx      <= '0;
         TxD           <= 1'b1;
         busy          <= 1'b0;
         send_complete <= 1'b0;
         dropped       <= 1'b0;
      end else begin
         send_complete <= 1'b0;
         dropped       <= (state != IDLE) && result.result_valid;
         case (state)
            IDLE: begin
               TxD <= 1'b1;
               if (result.result_valid) begin
                  x_sr     <= {16'd0, result.x_in};
                  y_sr     <= {12'd0, 1'b0, result.y_in};
                  conv_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= CONV;
               end
            end
            CONV: begin
               x_sr <= dabble_x(x_sr);
               y_sr <= dabble_y(y_sr);
               if (conv_cnt == 4'd9) begin
                  state <= START;
               end else begin
                  conv_cnt <= conv_cnt + 4'd1;
               end
            end
            START: begin
               TxD      <= 1'b0;
               baud_cnt <= '0;
               bit_idx  <= '0;
               byte_idx <= '0;
               state    <= SEND;
            end
            SEND: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  if (bit_idx == 4'd9) begin
                     bit_idx <= '0;
                     if (byte_idx == 4'd9) begin
                        byte_idx      <= '0;
                        TxD           <= 1'b1;
                        busy          <= 1'b0;
                        send_complete <= 1'b1;
                        state         <= IDLE;
                     end else begin
                        // Next start bit follows the stop bit with no idle gap.
                        byte_idx <= byte_idx + 4'd1;
                        TxD      <= 1'b0;
                     end
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                     TxD     <= (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_uart_tx.sv
// tb/tb_result_uart_tx.sv - directed bench for result_uart_tx with 10 clocks per bit
module tb_result_uart_tx;

   logic clock;
   logic reset;
   logic txd;
   logic busy;
   logic send_complete;
   logic dropped;

   int errors = 0;
   int checks = 0;

   logic txd_log  [0:1011];
   logic busy_log [0:1011];
   logic sc_log   [0:1011];
   logic drop_log [0:1011];

   result_uart_tx_if rif ();

   result_uart_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
      .clock         (clock),
      .reset         (reset),
      .result        (rif),
      .TxD           (txd),
      .busy          (busy),
      .send_complete (send_complete),
      .dropped       (dropped)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic sample(input int k);
      txd_log[k]  = txd;
      busy_log[k] = busy;
      sc_log[k]   = send_complete;
      drop_log[k] = dropped;
   endtask

   task automatic idle_check(input string tag, input int n);
      int bad;
      bad = 0;
      repeat (n) begin
         step();
         if (txd !== 1'b1 || busy !== 1'b0 || send_complete !== 1'b0 || dropped !== 1'b0) bad++;
      end
      check(tag, bad, 0);
   endtask

   // Accepts one result at edge N (offset 0) and records offsets 0..1011; drop_off > 0 injects
   // a second strobe (x=5, y=5) seen by edge N+drop_off.
   task automatic run_msg(input string tag, input logic [9:0] x, input logic [8:0] y,
                          input logic [79:0] exp_msg, input int drop_off);
      int bad_bits, bad_busy, bad_sc, bad_drop, first_low;
      logic [7:0] eb;
      logic [7:0] dec;
      logic       expb;
      rif.result_valid = 1'b1;
      rif.x_in         = x;
      rif.y_in         = y;
      step();
      sample(0);
      for (int k = 1; k <= 1011; k++) begin
         rif.result_valid = (k == drop_off);
         if (k == drop_off) begin
            rif.x_in = 10'd5;
            rif.y_in = 9'd5;
         end
         step();
         sample(k);
      end
      rif.result_valid = 1'b0;

      first_low = -1;
      for (int k = 0; k <= 1011; k++)
         if (first_low < 0 && txd_log[k] === 1'b0) first_low = k;
      check({tag, " first_low"}, first_low, 11);

      bad_bits = 0;
      for (int i = 0; i < 10; i++) begin
         eb = exp_msg[79-8*i -: 8];
         for (int b = 0; b < 10; b++) begin
            expb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : eb[b-1];
            for (int c = 0; c < 10; c++)
               if (txd_log[11 + 100*i + 10*b + c] !== expb) bad_bits++;
         end
         for (int b = 1; b <= 8; b++) dec[b-1] = txd_log[11 + 100*i + 10*b + 5];
         check($sformatf("%s byte%0d", tag, i), dec, eb);
      end
      check({tag, " bit_timing"}, bad_bits, 0);

      bad_busy = 0;
      bad_sc   = 0;
      bad_drop = 0;
      for (int k = 0; k <= 1010; k++) begin
         if (busy_log[k] !== 1'b1) bad_busy++;
         if (sc_log[k] !== 1'b0) bad_sc++;
      end
      for (int k = 0; k <= 1011; k++)
         if (drop_log[k] !== ((drop_off > 0) && (k == drop_off))) bad_drop++;
      check({tag, " busy_window"}, bad_busy, 0);
      check({tag, " busy_end"}, busy_log[1011], 0);
      check({tag, " complete_early"}, bad_sc, 0);
      check({tag, " complete_pulse"}, sc_log[1011], 1);
      check({tag, " txd_end"}, txd_log[1011], 1);
      check({tag, " dropped"}, bad_drop, 0);
   endtask

   initial begin
      reset            = 1'b1;
      rif.result_valid = 1'b0;
      rif.x_in         = '0;
      rif.y_in         = '0;
      repeat (3) step();
      check("reset txd", txd, 1);
      check("reset busy", busy, 0);
      check("reset complete", send_complete, 0);
      check("reset dropped", dropped, 0);
      reset = 1'b0;

      idle_check("idle 2000", 2000);

      run_msg("nominal", 10'd640, 9'd480, 80'h3036_3430_2C34_3830_0D0A, 0);
      idle_check("gap", 20);

      run_msg("max_drop", 10'd1023, 9'd511, 80'h3130_3233_2C35_3131_0D0A, 500);
      idle_check("no second message", 100);

      run_msg("zero", 10'd0, 9'd0, 80'h3030_3030_2C30_3030_0D0A, 0);
      run_msg("back_to_back", 10'd1, 9'd2, 80'h3030_3031_2C30_3032_0D0A, 0);

      // Abort during byte 3 (offsets 311..410 after acceptance).
      rif.result_valid = 1'b1;
      rif.x_in         = 10'd640;
      rif.y_in         = 9'd480;
      step();
      rif.result_valid = 1'b0;
      repeat (349) step();
      reset = 1'b1;
      step();
      check("abort txd", txd, 1);
      check("abort busy", busy, 0);
      check("abort complete", send_complete, 0);
      reset = 1'b0;
      idle_check("after abort", 1100);

      run_msg("after_reset", 10'd7, 9'd9, 80'h3030_3037_2C30_3039_0D0A, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
